// File: rtl/grf_wport_arbiter.sv
// Register-file write-port arbiter: writeback (fixed priority) vs. mul/div unit (valid/ready),
// with starvation stall and outstanding-result scoreboard. Optional trace via GRF_ARB_TRACE_EN.
module grf_wport_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic [31:0] wb_pc,
   input  logic        md_valid,
   input  logic [4:0]  md_addr,
   input  logic [31:0] md_data,
   input  logic [31:0] md_pc,
   output logic        md_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_addr,
   input  logic [4:0]  rd_a1,
   input  logic [4:0]  rd_a2,
   output logic        busy1,
   output logic        busy2,
   output logic        stall_req,
   output logic        grf_we,
   output logic [4:0]  grf_a3,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_pc
);

   localparam int unsigned NREG = 32;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

   logic             wb_req_c;
   logic             w_grant_c;
   logic             md_hs_c;
   logic             md_blocked_c;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             stall_req_q, stall_req_d;
   logic [NREG-1:0]  busy_q, busy_d;

   // Grant and port mux: zero-latency, W wins unless a starvation stall is active
   always_comb begin
      wb_req_c     = wb_we && (wb_addr != 5'd0);
      w_grant_c    = wb_req_c && !stall_req_q;
      md_ready     = !wb_req_c || stall_req_q;
      md_hs_c      = md_valid && md_ready;
      md_blocked_c = md_valid && !md_ready;
      grf_we       = 1'b0;
      grf_a3       = 5'd0;
      grf_wd       = 32'd0;
      grf_pc       = 32'd0;
      if (w_grant_c) begin
         grf_we = 1'b1;
         grf_a3 = wb_addr;
         grf_wd = wb_data;
         grf_pc = wb_pc;
      end else if (md_hs_c && (md_addr != 5'd0)) begin
         grf_we = 1'b1;
         grf_a3 = md_addr;
         grf_wd = md_data;
         grf_pc = md_pc;
      end
   end

   // Next state for starvation counter, stall flag and scoreboard
   always_comb begin
      wait_cnt_d  = wait_cnt_q;
      stall_req_d = stall_req_q;
      busy_d      = busy_q;
      if (md_blocked_c) begin
         if (wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end else begin
         wait_cnt_d = '0;
      end
      if (md_blocked_c && (wait_cnt_q == LIMIT_M1)) begin
         stall_req_d = 1'b1;
      end else if (md_hs_c || !md_valid) begin
         stall_req_d = 1'b0;
      end
      // Issue is applied after the clear so a same-register set wins
      if (md_hs_c) busy_d[md_addr] = 1'b0;
      if (issue_valid && (issue_addr != 5'd0)) busy_d[issue_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt_q  <= '0;
         stall_req_q <= 1'b0;
         busy_q      <= '0;
      end else begin
         wait_cnt_q  <= wait_cnt_d;
         stall_req_q <= stall_req_d;
         busy_q      <= busy_d;
      end
   end

   assign stall_req = stall_req_q;
   assign busy1     = busy_q[rd_a1];
   assign busy2     = busy_q[rd_a2];

`ifdef GRF_ARB_TRACE_EN
   always @(posedge clk) begin
      if (!reset) begin
         if (grf_we) $display("@%h: $%d <= %h", grf_pc, grf_a3, grf_wd);
         if (stall_req_q && wb_we) $display("ARB: wb dropped @%h", wb_pc);
      end
   end
`else
`endif

endmodule
